// File: rtl/gate_pkg.sv
// gate_pkg: mode codes, FSM encoding and parameter limits shared by the gate sweep checker
package gate_pkg;

    localparam int MODE_W = 3;
    localparam int CNT_W  = 4;

    localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
    localparam logic [MODE_W-1:0] MODE_NOR  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 8;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if: control, stimulus/response and result signals of the sweep checker
interface gate_sweep_checker_if #(parameter int N_IN = 2, parameter int ERR_W = 8);
    import gate_pkg::*;
    logic              start;
    logic [MODE_W-1:0] mode;
    logic [N_IN-1:0]   stim;
    logic              dut_y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [N_IN-1:0]   first_fail_vec;
    logic              first_fail_valid;
    logic              bad_mode;

    modport master (
        output start, mode, dut_y,
        input  stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid, bad_mode
    );

    modport slave (
        input  start, mode, dut_y,
        output stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid, bad_mode
    );
endinterface

// File: rtl/gate_ref_model.sv
// gate_ref_model: expected gate output, reducing the whole vector with the selected function
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [N_IN-1:0]   vec,
    output logic              y
);

    assign y = (mode == MODE_AND)  ?  (&vec) :
               (mode == MODE_OR)   ?  (|vec) :
               (mode == MODE_XOR)  ?  (^vec) :
               (mode == MODE_NAND) ? ~(&vec) :
               (mode == MODE_NOR)  ? ~(|vec) :
               (mode == MODE_XNOR) ? ~(^vec) : 1'b0;

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector to a gate DUT and checks its output against a reference
module gate_sweep_checker
    import gate_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input logic                clk,
    input logic                rst_n,
    gate_sweep_checker_if.slave bus
);

    state_t            state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffvalid_q, ffvalid_d;
    logic              pass_q, pass_d;
    logic              bad_q, bad_d;
    logic              ref_y;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .mode (mode_q),
        .vec  (stim_q),
        .y    (ref_y)
    );

    // Sweep sequencing: accept start, settle each vector, check it, then report once
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        stim_d    = stim_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;
        bad_d     = bad_q;
        case (state_q)
            S_IDLE: begin
                stim_d = '0;
                if (bus.start) begin
                    mode_d    = bus.mode;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    ffvalid_d = 1'b0;
                    ffv_d     = '0;
                    bad_d     = bus.mode > MODE_XNOR;
                    cnt_d     = CNT_W'(SETTLE);
                    state_d   = (bus.mode > MODE_XNOR) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? S_CHECK : S_WAIT;
            end
            S_CHECK: begin
                if (bus.dut_y != ref_y) begin
                    err_d = (&err_q) ? err_q : err_q + 1'b1;
                    if (!ffvalid_q) begin
                        ffv_d     = stim_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (stim_q == {N_IN{1'b1}}) begin
                    pass_d  = ~bad_q & (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = CNT_W'(SETTLE);
                    state_d = S_WAIT;
                end
            end
            default: begin
                stim_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            cnt_q     <= '0;
            stim_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            stim_q    <= stim_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
            bad_q     <= bad_d;
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign bus.done             = state_q == S_DONE;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;
    assign bus.bad_mode         = bad_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: random and directed sweeps of two checker configurations against a counting model
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_in;
    logic [2:0] mode_in;
    logic [2:0] sweep_mode;
    logic [7:0] mask;
    bit         sel;
    int         n_vec = 0;
    int         n_bad = 0;

    logic       o_busy, o_done, o_pass, o_ffvalid, o_bad;
    logic [7:0] o_stim, o_err, o_ffv;

    always #5 clk = ~clk;

    gate_sweep_checker_if #(.N_IN(2), .ERR_W(8)) ifa ();
    gate_sweep_checker_if #(.N_IN(3), .ERR_W(2)) ifb ();

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    gate_sweep_checker #(.N_IN(3), .SETTLE(3), .ERR_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    function automatic bit tb_gate(input logic [2:0] m, input int n, input logic [7:0] v);
        int ones = 0;
        bit r;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        r = (m % 3 == 0) ? (ones == n) : (m % 3 == 1) ? (ones > 0) : ones[0];
        return (m >= 3) ? !r : r;
    endfunction

    function automatic logic [7:0] tie_mask(input logic [2:0] m, input int n, input bit c);
        logic [7:0] r = '0;
        for (int v = 0; v < (1 << n); v++) r[v] = tb_gate(m, n, 8'(v)) ^ c;
        return r;
    endfunction

    assign ifa.start = !sel && start_in;
    assign ifb.start = sel && start_in;
    assign ifa.mode  = mode_in;
    assign ifb.mode  = mode_in;

    always_comb ifa.dut_y = tb_gate(sweep_mode, 2, 8'(ifa.stim)) ^ mask[ifa.stim];
    always_comb ifb.dut_y = tb_gate(sweep_mode, 3, 8'(ifb.stim)) ^ mask[ifb.stim];

    always_comb begin
        o_busy    = sel ? ifb.busy : ifa.busy;
        o_done    = sel ? ifb.done : ifa.done;
        o_pass    = sel ? ifb.pass : ifa.pass;
        o_ffvalid = sel ? ifb.first_fail_valid : ifa.first_fail_valid;
        o_bad     = sel ? ifb.bad_mode : ifa.bad_mode;
        o_stim    = sel ? 8'(ifb.stim) : 8'(ifa.stim);
        o_err     = sel ? 8'(ifb.err_count) : 8'(ifa.err_count);
        o_ffv     = sel ? 8'(ifb.first_fail_vec) : 8'(ifa.first_fail_vec);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {ifa.stim, ifa.busy, ifa.done, ifa.pass, ifa.err_count,
                            ifa.first_fail_vec, ifa.first_fail_valid, ifa.bad_mode}, 0);
        check({tag, "_b"}, {ifb.stim, ifb.busy, ifb.done, ifb.pass, ifb.err_count,
                            ifb.first_fail_vec, ifb.first_fail_valid, ifb.bad_mode}, 0);
    endtask

    task automatic sweep(input bit s, input logic [2:0] m, input logic [7:0] msk, input bit poke);
        int n, st, emax, kd, cnt, first;
        bit bad;
        logic [7:0] err_exp;
        n     = s ? 3 : 2;
        st    = s ? 3 : 1;
        emax  = s ? 3 : 255;
        bad   = m > 3'd5;
        cnt   = 0;
        first = 0;
        for (int v = (1 << n) - 1; v >= 0; v--) if (msk[v] && !bad) begin cnt++; first = v; end
        err_exp = 8'((cnt > emax) ? emax : cnt);
        kd = bad ? 1 : (1 << n) * (st + 1) + 1;
        @(negedge clk);
        sel = s; sweep_mode = m; mask = msk; mode_in = m; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        for (int k = 1; k <= kd; k++) begin
            if (k > 1) @(negedge clk);
            if (k < kd) begin
                check("done_early", o_done, 0);
                check("busy", o_busy, 1);
                check("stim", o_stim, (k - 1) / (st + 1));
            end else begin
                check("done", o_done, 1);
                check("busy_at_done", o_busy, 0);
                check("pass", o_pass, !bad && cnt == 0);
                check("err_count", o_err, err_exp);
                check("ff_valid", o_ffvalid, cnt > 0);
                check("ff_vec", o_ffv, first);
                check("bad_mode", o_bad, bad);
                if (bad) check("stim_bad", o_stim, 0);
            end
            if (poke) begin
                start_in = (k == 3);
                if (k == 4) mode_in = m ^ 3'd1;
            end
        end
        start_in = 1'b0;
        @(negedge clk);
        check("done_single", o_done, 0);
        check("idle_busy", o_busy, 0);
        check("idle_stim", o_stim, 0);
        check("hold_err", o_err, err_exp);
        check("hold_pass", o_pass, !bad && cnt == 0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        sel = 1'b0; sweep_mode = 3'd0; mask = '0; mode_in = 3'd0; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_stim", o_stim, 1);
        check("pre_reset_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        repeat (3) begin
            @(negedge clk);
            check("reset_no_done", o_done, 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start_in = 1'b0; mode_in = '0; sweep_mode = '0; mask = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        sweep(1'b0, 3'd0, 8'h00, 1'b0);
        sweep(1'b0, 3'd0, tie_mask(3'd0, 2, 1'b0), 1'b0);
        sweep(1'b1, 3'd2, tie_mask(3'd2, 3, 1'b1), 1'b0);
        sweep(1'b0, 3'd6, 8'h00, 1'b0);
        sweep(1'b1, 3'd4, 8'hFF, 1'b0);
        sweep(1'b1, 3'd7, 8'h00, 1'b0);
        sweep(1'b0, 3'd1, 8'h05, 1'b1);
        reset_mid();
        sweep(1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 24; i++) begin
            logic [2:0] m;
            logic [7:0] msk;
            m   = 3'($urandom_range(0, 7));
            msk = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            sweep(1'($urandom), m, msk, 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
